// File: rtl/fpga_cfg_loader.sv
// Configuration sequencer for the 2x2 fabric: turns a word-wide bitstream into
// serial shifts on the connection chain, then the CLB chain, and gates fabric_en.
module fpga_cfg_loader #(
  parameter int CONN_CHAIN_LEN = 256,
  parameter int CLB_CHAIN_LEN  = 80,
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  scan_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  output logic                  busy,
  output logic                  done,
  output logic                  fabric_en
);

  localparam int TOTAL = CONN_CHAIN_LEN + CLB_CHAIN_LEN;
  localparam int BCW   = $clog2(DATA_WIDTH + 1);
  localparam int SW    = CNT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CONN, CLB, DONE} state_t;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] sbuf, sbuf_d;
  logic [BCW-1:0]        buf_cnt, buf_cnt_d;
  logic [CNT_WIDTH-1:0]  bit_idx, bit_idx_d;
  logic                  cfg_ready_d, conn_scan_in_d, conn_scan_en_d;
  logic                  clb_scan_in_d, clb_scan_en_d, busy_d, done_d, fabric_en_d;
  logic                  accept, shift, bit_out;
  logic [SW-1:0]         pending;

  assign accept = cfg_valid & cfg_ready;

  always_ff @(posedge scan_clk) begin
    if (rst) begin
      state        <= IDLE;
      sbuf         <= '0;
      buf_cnt      <= '0;
      bit_idx      <= '0;
      cfg_ready    <= 1'b0;
      conn_scan_in <= 1'b0;
      conn_scan_en <= 1'b0;
      clb_scan_in  <= 1'b0;
      clb_scan_en  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fabric_en    <= 1'b0;
    end else begin
      state        <= state_d;
      sbuf         <= sbuf_d;
      buf_cnt      <= buf_cnt_d;
      bit_idx      <= bit_idx_d;
      cfg_ready    <= cfg_ready_d;
      conn_scan_in <= conn_scan_in_d;
      conn_scan_en <= conn_scan_en_d;
      clb_scan_in  <= clb_scan_in_d;
      clb_scan_en  <= clb_scan_en_d;
      busy         <= busy_d;
      done         <= done_d;
      fabric_en    <= fabric_en_d;
    end
  end

  always_comb begin
    state_d        = state;
    sbuf_d         = sbuf;
    buf_cnt_d      = buf_cnt;
    bit_idx_d      = bit_idx;
    cfg_ready_d    = 1'b0;
    conn_scan_in_d = 1'b0;
    conn_scan_en_d = 1'b0;
    clb_scan_in_d  = 1'b0;
    clb_scan_en_d  = 1'b0;
    busy_d         = busy;
    done_d         = 1'b0;
    fabric_en_d    = fabric_en;
    shift          = 1'b0;
    bit_out        = 1'b0;
    pending        = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = CONN;
          bit_idx_d   = '0;
          buf_cnt_d   = '0;
          busy_d      = 1'b1;
          fabric_en_d = 1'b0;
          cfg_ready_d = 1'b1;
        end
      end
      CONN, CLB: begin
        if (state == CLB && bit_idx == CNT_WIDTH'(TOTAL)) begin
          // Last bit was presented last cycle; drop any pad bits and release the fabric.
          state_d     = DONE;
          buf_cnt_d   = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          fabric_en_d = 1'b1;
        end else begin
          // An empty buffer shifts the incoming word's MSB straight out so an
          // accepted word appears on scan_in in the very next cycle.
          if (buf_cnt != '0) begin
            shift   = 1'b1;
            bit_out = sbuf[DATA_WIDTH-1];
            if (accept) begin
              sbuf_d    = cfg_data;
              buf_cnt_d = BCW'(DATA_WIDTH);
            end else begin
              sbuf_d    = sbuf << 1;
              buf_cnt_d = buf_cnt - BCW'(1);
            end
          end else if (accept) begin
            shift     = 1'b1;
            bit_out   = cfg_data[DATA_WIDTH-1];
            sbuf_d    = cfg_data << 1;
            buf_cnt_d = BCW'(DATA_WIDTH - 1);
          end
          if (shift) begin
            bit_idx_d = bit_idx + CNT_WIDTH'(1);
            if (state == CONN) begin
              conn_scan_in_d = bit_out;
              conn_scan_en_d = 1'b1;
              if (bit_idx == CNT_WIDTH'(CONN_CHAIN_LEN - 1)) state_d = CLB;
            end else begin
              clb_scan_in_d = bit_out;
              clb_scan_en_d = 1'b1;
            end
          end
          // Only ask for another word while the pass still needs bits beyond the buffer.
          pending     = SW'(bit_idx_d) + SW'(buf_cnt_d);
          cfg_ready_d = (buf_cnt_d <= BCW'(1)) && (pending < SW'(TOTAL));
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
